ft_recovery_sequencer: RTL and testbench
========================================

// Module: ft_recovery_sequencer
// PURPOSE
//  Sequences the register-file and PC copy for fault recovery in the FTM lockstep cluster.
//  - Triggered by ft_control's recover level.
//  - Streams every architectural register from the voted read port into the write ports of the flagged cores.
//  - Restores the voted PC, then pulses recovery_done back to ft_control (its WAIT_RECOVERY_FINISH exit).
// PARAMETERS
//  NUM_CORES  3   lockstep cores receiving write enables
//  NUM_REGS   32  architectural registers to copy
//  ADDR_W     5   register address width, $clog2(NUM_REGS)
//  DATA_W     32  register/PC width
//  READ_LAT   1   cycles from rf_raddr_o to valid rf_rdata_i (>=1)
//  SKIP_R0    1   1: register 0 is hardwired and not copied
// PORTS
//  clk_i            in   1          clock; all state updates on posedge
//  rst_i            in   1          synchronous, active-high reset
//  recover_i        in   1          recovery request level from ft_control
//  faulty_mask_i    in   NUM_CORES  cores flagged by the voter; sampled at start
//  rf_re_o          in/out: out 1          voted RF read strobe
//  rf_raddr_o       out  ADDR_W     voted RF read address
//  rf_rdata_i       in   DATA_W     voted RF read data, valid READ_LAT cycles after rf_re_o
//  rf_we_o          out  NUM_CORES  per-core RF write enable
//  rf_waddr_o       out  ADDR_W     RF write address, shared by all cores
//  rf_wdata_o       out  DATA_W     RF write data, shared by all cores
//  pc_i             in   DATA_W     voted PC
//  pc_we_o          out  NUM_CORES  per-core PC load enable
//  pc_o             out  DATA_W     PC value to load
//  busy_o           out  1          sequence in progress
//  recovery_done_o  out  1          one-cycle completion pulse
// BEHAVIOUR
//  Reset: state IDLE; delay pipe cleared.
//   - All outputs are 0: re/we/pc_we/busy/done.
//   - raddr/waddr/wdata/pc_o are also 0.
//  Start (IDLE only): recover_i=1 and rec_q=0 (rising edge; rec_q is recover_i registered).
//   - Latch mask_q = faulty_mask_i, or all ones if faulty_mask_i==0.
//   - Set raddr = SKIP_R0 and go to COPY.
//  COPY:
//   - Each cycle: rf_re_o=1 and raddr increments.
//   - After NUM_REGS-1 is issued, go to DRAIN.
//  DRAIN:
//   - No reads are issued.
//   - Stay READ_LAT cycles until the pipe is empty, then go to PC.
//  Write path: a READ_LAT-deep pipe carries {valid, addr}.
//   - When the pipe output is valid: rf_we_o = mask_q, rf_waddr_o = pipe addr, rf_wdata_o = rf_rdata_i.
//   - Otherwise rf_we_o = 0.
//  PC: one cycle of pc_we_o = mask_q and pc_o = pc_i; then go to DONE.
//  DONE: recovery_done_o=1 for one cycle; then go to IDLE.
//  busy_o=1 in COPY/DRAIN/PC/DONE.
//  Timing (start sampled at edge 0, SKIP_R0=1, NUM_REGS=32):
//   - Reads of addr 1..31 occur in cycles 1..31.
//   - Write of addr k occurs in cycle k+READ_LAT.
//   - PC write occurs in cycle 32+READ_LAT.
//   - Done pulse occurs in cycle 33+READ_LAT.
//  Address arithmetic:
//   - raddr is ADDR_W wide and never wraps; the last-address compare happens before the increment.
//   - If NUM_REGS=2**ADDR_W, the final increment is suppressed.
//  Restart: a rising recover_i while busy_o=1 aborts the sequence.
//   - Flush the pipe, re-latch the mask, restart at SKIP_R0 next cycle.
//   - No done pulse for the aborted run.
//  Held recover_i: recover_i still high after DONE does not restart; a new rising edge is required.
//  Reset mid-sequence: next cycle is IDLE with all enables 0; writes in flight are dropped.
//  Enables are mutually exclusive by construction: rf_we_o != 0 never coincides with pc_we_o != 0.
// STRUCTURE
//  ftm_pkg: seq_state_e {IDLE,COPY,DRAIN,PC,DONE}, NUM_CORES_DEF, DATA_W_DEF.
//  Sub-module ft_delay_line #(W,DEPTH): synchronous-reset shift register.
//   - Carries {valid, addr} across READ_LAT stages.
//   - Has a flush input used on restart.
// TESTING
//  1. Reset, pulse recover_i, mask=3'b010, READ_LAT=1:
//     - Reads 1..31 in cycles 1..31.
//     - rf_we_o=3'b010 with addr k in cycle k+1; wdata equals the model RF.
//     - pc_we_o=3'b010 in cycle 33; done in cycle 34 only.
//  2. mask=3'b000 -> every write and the PC load use 3'b111.
//  3. READ_LAT=3 -> last write in cycle 34, PC in 35, done in 36; no write enable during PC.
//  4. Re-raise recover_i in cycle 10 with mask=3'b001:
//     - Reads restart at addr 1 in cycle 11.
//     - Exactly one done pulse overall, with mask 3'b001.
//  5. Assert rst_i in cycle 15 -> cycle 16 is IDLE, all outputs 0; no done pulse.
//  6. Hold recover_i high for 100 cycles -> exactly one sequence and one done; busy_o=0 after it.

Source files
------------

// File: rtl/ftm_pkg.sv
// Shared types and defaults for the FTM lockstep recovery path.
package ftm_pkg;
    typedef enum logic [2:0] {IDLE, COPY, DRAIN, PC, DONE} seq_state_e;

    localparam int NUM_CORES_DEF = 3;
    localparam int DATA_W_DEF    = 32;
endpackage

// File: rtl/ft_delay_line.sv
// Fixed-depth shift register with synchronous reset and a flush that empties every stage.
module ft_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [DEPTH-1:0][W-1:0] stage_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/ft_recovery_sequencer.sv
// Copies the voted register file and PC into the flagged lockstep cores, then pulses done.
module ft_recovery_sequencer
    import ftm_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int READ_LAT  = 1,
    parameter int SKIP_R0   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 recover_i,
    input  logic [NUM_CORES-1:0] faulty_mask_i,
    output logic                 rf_re_o,
    output logic [ADDR_W-1:0]    rf_raddr_o,
    input  logic [DATA_W-1:0]    rf_rdata_i,
    output logic [NUM_CORES-1:0] rf_we_o,
    output logic [ADDR_W-1:0]    rf_waddr_o,
    output logic [DATA_W-1:0]    rf_wdata_o,
    input  logic [DATA_W-1:0]    pc_i,
    output logic [NUM_CORES-1:0] pc_we_o,
    output logic [DATA_W-1:0]    pc_o,
    output logic                 busy_o,
    output logic                 recovery_done_o
);
    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(SKIP_R0);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(READ_LAT - 1);

    seq_state_e state_q, state_d;
    logic                 rec_q, start, last_rd;
    logic [NUM_CORES-1:0] mask_q;
    logic [ADDR_W-1:0]    raddr_q;
    logic [CNT_W-1:0]     drain_cnt_q;
    logic                 pipe_vld;
    logic [ADDR_W-1:0]    pipe_addr;

    // Any rising edge of recover_i restarts, including mid-sequence aborts.
    assign start   = recover_i && !rec_q;
    assign last_rd = (state_q == COPY) && (raddr_q == LAST_ADDR);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = COPY;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                COPY:    if (last_rd) state_d = DRAIN;
                DRAIN:   if (drain_cnt_q == '0) state_d = PC;
                PC:      state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Address holds at the last register so a full 2**ADDR_W file never wraps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rec_q       <= 1'b0;
            mask_q      <= '0;
            raddr_q     <= '0;
            drain_cnt_q <= '0;
        end else begin
            rec_q <= recover_i;
            if (start) begin
                mask_q  <= (faulty_mask_i == '0) ? '1 : faulty_mask_i;
                raddr_q <= FIRST_ADDR;
            end else if (last_rd) begin
                drain_cnt_q <= DRAIN_LAST;
            end else if (state_q == COPY) begin
                raddr_q <= raddr_q + 1'b1;
            end else if (state_q == DRAIN && drain_cnt_q != '0) begin
                drain_cnt_q <= drain_cnt_q - 1'b1;
            end
        end
    end

    ft_delay_line #(.W(ADDR_W + 1), .DEPTH(READ_LAT)) u_rd_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (start),
        .d_i     ({rf_re_o, raddr_q}),
        .q_o     ({pipe_vld, pipe_addr})
    );

    always_comb begin
        rf_re_o         = (state_q == COPY);
        busy_o          = (state_q != IDLE);
        recovery_done_o = (state_q == DONE);
        pc_we_o         = (state_q == PC) ? mask_q : '0;
        pc_o            = (state_q == PC) ? pc_i : '0;
        rf_we_o         = pipe_vld ? mask_q : '0;
        rf_waddr_o      = pipe_vld ? pipe_addr : '0;
        rf_wdata_o      = pipe_vld ? rf_rdata_i : '0;
    end

    assign rf_raddr_o = raddr_q;
endmodule

// File: tb/tb_ft_recovery_sequencer.sv
// Runs READ_LAT=1 and READ_LAT=3 sequencers side by side against a cycle-offset reference model.
module tb_ft_recovery_sequencer;
    localparam int NC = 3, NR = 32, AW = 5, DW = 32;

    logic clk = 1'b0;
    logic rst, recover;
    logic [NC-1:0] fmask;
    logic [DW-1:0] pc;
    always #5 clk = ~clk;

    logic [1:0]          re, busy, done;
    logic [1:0][AW-1:0]  raddr, waddr;
    logic [1:0][DW-1:0]  rdata, wdata, pco;
    logic [1:0][NC-1:0]  we, pcwe;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ft_recovery_sequencer #(
            .NUM_CORES(NC), .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW),
            .READ_LAT(g == 0 ? 1 : 3), .SKIP_R0(1)
        ) dut (
            .clk_i(clk), .rst_i(rst), .recover_i(recover), .faulty_mask_i(fmask),
            .rf_re_o(re[g]), .rf_raddr_o(raddr[g]), .rf_rdata_i(rdata[g]),
            .rf_we_o(we[g]), .rf_waddr_o(waddr[g]), .rf_wdata_o(wdata[g]),
            .pc_i(pc), .pc_we_o(pcwe[g]), .pc_o(pco[g]),
            .busy_o(busy[g]), .recovery_done_o(done[g])
        );
    end

    // Voted register file: data appears exactly READ_LAT cycles after the address.
    logic [DW-1:0] mem [NR];
    logic [1:0][AW-1:0] h0, h1, h2;
    always @(posedge clk) begin
        h0 <= raddr;
        h1 <= h0;
        h2 <= h1;
    end
    assign rdata[0] = mem[h0[0]];
    assign rdata[1] = mem[h2[1]];

    // Reference: each run is just an offset d since its start edge plus a mask.
    bit            act   [2];
    int            d     [2];
    logic [NC-1:0] mk    [2];
    bit            rprev [2];
    logic [AW-1:0] ra_m  [2];
    int            n_done[2];
    int            checks = 0, passed = 0;

    function automatic int lat(int j);
        return (j == 0) ? 1 : 3;
    endfunction

    task automatic chk(string tag, int j, logic [63:0] obs, logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s[lat%0d]: observed %0h expected %0h", tag, lat(j), obs, exp);
    endtask

    task automatic model_edge(int j);
        int L = lat(j);
        if (rst) begin
            act[j] = 0; d[j] = 0; rprev[j] = 0; ra_m[j] = '0;
        end else begin
            if (recover && !rprev[j]) begin
                act[j] = 1; d[j] = 1; ra_m[j] = AW'(1);
                mk[j] = (fmask == '0) ? '1 : fmask;
            end else if (act[j]) begin
                d[j] = d[j] + 1;
                if (d[j] <= NR - 1) ra_m[j] = AW'(d[j]);
                if (d[j] > NR + 1 + L) act[j] = 0;
            end
            rprev[j] = recover;
        end
    endtask

    task automatic check_all(int j);
        int L = lat(j);
        int dd = d[j];
        bit wr = act[j] && dd >= 1 + L && dd <= NR - 1 + L;
        bit pcw = act[j] && dd == NR + L;
        chk("rf_re",   j, re[j],    act[j] && dd >= 1 && dd <= NR - 1);
        chk("raddr",   j, raddr[j], ra_m[j]);
        chk("rf_we",   j, we[j],    wr ? mk[j] : '0);
        chk("waddr",   j, waddr[j], wr ? AW'(dd - L) : '0);
        chk("wdata",   j, wdata[j], wr ? mem[dd - L] : '0);
        chk("pc_we",   j, pcwe[j],  pcw ? mk[j] : '0);
        chk("pc_o",    j, pco[j],   pcw ? pc : '0);
        chk("busy",    j, busy[j],  act[j]);
        chk("done",    j, done[j],  act[j] && dd == NR + 1 + L);
        chk("excl",    j, (we[j] != '0) && (pcwe[j] != '0), 1'b0);
        if (done[j]) n_done[j]++;
    endtask

    task automatic step();
        pc = $urandom;
        @(posedge clk);
        for (int j = 0; j < 2; j++) model_edge(j);
        #1;
        for (int j = 0; j < 2; j++) check_all(j);
    endtask

    task automatic pulse(logic [NC-1:0] m);
        fmask = m;
        recover = 1'b1;
        step();
        recover = 1'b0;
    endtask

    task automatic clr_done();
        n_done[0] = 0;
        n_done[1] = 0;
    endtask

    task automatic chk_done(string tag, int n);
        for (int j = 0; j < 2; j++) chk(tag, j, n_done[j], n);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) mem[i] = $urandom;
        rst = 1'b1; recover = 1'b0; fmask = '0; pc = '0;
        for (int j = 0; j < 2; j++) begin
            act[j] = 0; d[j] = 0; mk[j] = '0; rprev[j] = 0; ra_m[j] = '0;
        end
        clr_done();
        step(); step();
        rst = 1'b0;
        step();

        // Single flagged core, then zero mask meaning all cores.
        clr_done(); pulse(3'b010); repeat (40) step(); chk_done("done_cnt_mask010", 1);
        clr_done(); pulse(3'b000); repeat (40) step(); chk_done("done_cnt_mask000", 1);

        // Abort and restart mid-copy with a new mask.
        clr_done(); pulse(3'b100); repeat (9) step();
        pulse(3'b001); repeat (42) step(); chk_done("done_cnt_restart", 1);

        // Reset mid-sequence drops everything in flight.
        clr_done(); pulse(3'b011); repeat (14) step();
        rst = 1'b1; step(); rst = 1'b0;
        repeat (40) step(); chk_done("done_cnt_reset", 0);

        // Held request runs exactly once.
        clr_done(); fmask = 3'($urandom); recover = 1'b1;
        repeat (100) step();
        recover = 1'b0; repeat (3) step(); chk_done("done_cnt_held", 1);

        // Randomized masks and restart points, including restarts during drain/PC/done.
        for (int r = 0; r < 6; r++) begin
            clr_done();
            pulse(3'($urandom));
            repeat ($urandom_range(1, 38)) step();
            pulse(3'($urandom));
            repeat (42) step();
            chk_done("done_cnt_rand", 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
